// File: rtl/idea_pkg.sv
// Shared opcodes, state encoding and default width for the IDEA arithmetic unit.
package idea_pkg;

   localparam int IDEA_W = 16;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_XOR = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_SUB = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_RED  = 2'd2,
      S_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/idea_arith_if.sv
// Operation request / result handshake between the round controller and the arithmetic unit.
interface idea_arith_if
   import idea_pkg::*;
#(
   parameter int W = IDEA_W
);
   logic         in_valid;
   logic         in_ready;
   logic [1:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         busy;

   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, out_data, busy
   );

   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, out_data, busy
   );
endinterface

// File: rtl/idea_mulmod_seq.sv
// Shift-add multiplier (W iterations) and the mod 2^W+1 reduction, where operand 0 stands for 2^W.
module idea_mulmod_seq
   import idea_pkg::*;
#(
   parameter int W     = IDEA_W,
   parameter int CNT_W = $clog2(W + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         done,
   output logic [W-1:0] result
);
   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   logic [W-1:0]     a_reg;
   logic [W-1:0]     b_reg;
   logic [2*W-1:0]   mcand;
   logic [W-1:0]     mplier;
   logic [2*W-1:0]   acc;
   logic [CNT_W-1:0] cnt;
   logic             run;
   logic [W-1:0]     lo;
   logic [W-1:0]     hi;

   assign done = run && (cnt == CNT_W'(W - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg  <= '0;
         b_reg  <= '0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
         run    <= 1'b0;
      end else if (start) begin
         a_reg  <= a;
         b_reg  <= b;
         mcand  <= {{W{1'b0}}, a};
         mplier <= b;
         acc    <= '0;
         cnt    <= '0;
         run    <= 1'b1;
      end else if (run) begin
         if (mplier[0]) acc <= acc + mcand;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + CNT_W'(1);
         if (done) run <= 1'b0;
      end
   end

   assign lo = acc[W-1:0];
   assign hi = acc[2*W-1:W];

   // 2^W == -1 mod 2^W+1, so a zero operand turns the product into 1 - other.
   always_comb begin
      result = '0;
      if (a_reg == '0)
         result = ONE - b_reg;
      else if (b_reg == '0)
         result = ONE - a_reg;
      else
         result = lo - hi + {{(W-1){1'b0}}, (lo < hi)};
   end
endmodule

// File: rtl/idea_arith_unit.sv
// Handshaked IDEA arithmetic unit: single-cycle ADD/XOR/SUB, sequential MUL mod 2^W+1.
//  state  | meaning
//  S_IDLE | ready for a new operation
//  S_MUL  | shift-add iterations running
//  S_RED  | mod 2^W+1 reduction, result written
//  S_DONE | result presented until out_ready
module idea_arith_unit
   import idea_pkg::*;
#(
   parameter int W     = IDEA_W,
   parameter int CNT_W = $clog2(W + 1)
) (
   input logic         clk,
   input logic         rst,
   idea_arith_if.slave bus
);
   state_t       state;
   state_t       state_nxt;
   logic         accept;
   logic         mul_start;
   logic         mul_done;
   logic [W-1:0] alu_res;
   logic [W-1:0] mul_result;
   logic [W-1:0] out_data_q;

   assign accept    = (state == S_IDLE) && bus.in_valid;
   assign mul_start = accept && (bus.op == OP_MUL);

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept) state_nxt = (bus.op == OP_MUL) ? S_MUL : S_DONE;
         S_MUL:   if (mul_done) state_nxt = S_RED;
         S_RED:   state_nxt = S_DONE;
         S_DONE:  if (bus.out_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      alu_res = '0;
      case (bus.op)
         OP_ADD:  alu_res = bus.a + bus.b;
         OP_XOR:  alu_res = bus.a ^ bus.b;
         OP_SUB:  alu_res = bus.a - bus.b;
         default: alu_res = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         out_data_q <= '0;
      else if (accept && (bus.op != OP_MUL))
         out_data_q <= alu_res;
      else if (state == S_RED)
         out_data_q <= mul_result;
   end

   assign bus.in_ready  = (state == S_IDLE);
   assign bus.out_valid = (state == S_DONE);
   assign bus.busy      = (state != S_IDLE);
   assign bus.out_data  = out_data_q;

   idea_mulmod_seq #(
      .W     (W),
      .CNT_W (CNT_W)
   ) u_mulmod (
      .clk    (clk),
      .rst    (rst),
      .start  (mul_start),
      .a      (bus.a),
      .b      (bus.b),
      .done   (mul_done),
      .result (mul_result)
   );
endmodule

// File: tb/tb_idea_arith_unit.sv
// Scoreboard bench for idea_arith_unit at W=16: directed cases, back-to-back, reset abort, random ops.
module tb_idea_arith_unit;
   import idea_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   logic [15:0] exp_q[$];

   idea_arith_if #(.W(16)) bus ();

   idea_arith_unit #(.W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] ref_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
      longint unsigned aa, bb, p;
      case (op)
         OP_ADD: return a + b;
         OP_XOR: return a ^ b;
         OP_SUB: return a - b;
         default: begin
            aa = (a == 16'h0) ? 64'd65536 : 64'(a);
            bb = (b == 16'h0) ? 64'd65536 : 64'(b);
            p  = (aa * bb) % 64'd65537;
            return (p == 64'd65536) ? 16'h0 : p[15:0];
         end
      endcase
   endfunction

   // Presents an operation from a negedge and returns just after its accept edge.
   task automatic drive_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b, output bit ok);
      @(negedge clk);
      bus.in_valid = 1'b1; bus.op = op; bus.a = a; bus.b = b;
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         ok = bus.in_ready;
         @(posedge clk);
      end
      #1;
      bus.in_valid = 1'b0;
      bus.op = 2'($urandom); bus.a = 16'($urandom); bus.b = 16'($urandom);
   endtask

   task automatic wait_valid(output int lat, output bit ok);
      ok = 1'b0; lat = 0;
      for (int i = 1; i <= 100 && !ok; i++) begin
         @(negedge clk);
         lat = i;
         ok  = bus.out_valid;
      end
   endtask

   task automatic consume;
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op = OP_ADD; bus.a = 16'h0; bus.b = 16'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
      checks++; if (bus.out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data got %h want 0000", bus.out_data); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
      rst = 1'b0;
   endtask

   task automatic test_add_hold;
      bit ok; int lat; logic [15:0] e;
      exp_q.push_back(ref_op(OP_ADD, 16'hFFFF, 16'h0002));
      drive_op(OP_ADD, 16'hFFFF, 16'h0002, ok);
      checks++; if (!ok) begin errors++; $display("FAIL add_accept got timeout want accept"); end
      wait_valid(lat, ok);
      e = exp_q.pop_front();
      checks++; if (!ok || lat != 1) begin errors++; $display("FAIL add_latency got %0d want 1", lat); end
      checks++; if (bus.out_data !== e || e !== 16'h0001) begin errors++; $display("FAIL add_data got %h want 0001", bus.out_data); end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0001 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL add_hold got v=%b d=%h r=%b busy=%b want v=1 d=0001 r=0 busy=1",
                     bus.out_valid, bus.out_data, bus.in_ready, bus.busy);
         end
      end
      consume();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== 16'h0001) begin
         errors++;
         $display("FAIL add_release got v=%b r=%b d=%h want v=0 r=1 d=0001", bus.out_valid, bus.in_ready, bus.out_data);
      end
   endtask

   task automatic test_xor_sub;
      logic [1:0]  ops[2] = '{OP_XOR, OP_SUB};
      logic [15:0] as[2]  = '{16'hA5A5, 16'h0000};
      logic [15:0] bs[2]  = '{16'h0F0F, 16'h0001};
      logic [15:0] want[2] = '{16'hAAAA, 16'hFFFF};
      bit ok; int lat; logic [15:0] e;
      for (int k = 0; k < 2; k++) begin
         exp_q.push_back(want[k]);
         drive_op(ops[k], as[k], bs[k], ok);
         wait_valid(lat, ok);
         e = exp_q.pop_front();
         checks++; if (!ok || lat != 1) begin errors++; $display("FAIL xor_sub_latency[%0d] got %0d want 1", k, lat); end
         checks++; if (bus.out_data !== e) begin errors++; $display("FAIL xor_sub_data[%0d] got %h want %h", k, bus.out_data, e); end
         consume();
      end
   endtask

   task automatic test_mul;
      logic [15:0] as[5]   = '{16'h0003, 16'hFFFF, 16'h8000, 16'h0000, 16'h0000};
      logic [15:0] bs[5]   = '{16'h0005, 16'hFFFF, 16'h0002, 16'h0000, 16'h0002};
      logic [15:0] want[5] = '{16'h000F, 16'h0004, 16'h0000, 16'h0001, 16'hFFFF};
      bit ok; int lat; logic [15:0] e;
      for (int k = 0; k < 5; k++) begin
         exp_q.push_back(want[k]);
         drive_op(OP_MUL, as[k], bs[k], ok);
         wait_valid(lat, ok);
         e = exp_q.pop_front();
         checks++; if (!ok || lat != 18) begin errors++; $display("FAIL mul_latency[%0d] got %0d want 18", k, lat); end
         checks++; if (bus.out_data !== e) begin errors++; $display("FAIL mul_data[%0d] got %h want %h", k, bus.out_data, e); end
         consume();
      end
   endtask

   task automatic test_back_to_back;
      bit ok; int n_out, acc2; logic [15:0] e;
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b1; bus.op = OP_ADD; bus.a = 16'h0003; bus.b = 16'h0004;
      exp_q.push_back(16'h0007);
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         ok = bus.in_ready;
         @(posedge clk);
      end
      checks++; if (!ok) begin errors++; $display("FAIL b2b_first_accept got timeout want accept"); end
      #1 bus.op = OP_MUL; bus.a = 16'h0003; bus.b = 16'h0005;
      exp_q.push_back(16'h000F);
      acc2 = 0; n_out = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            n_out++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL b2b_extra got %h want no output", bus.out_data);
            end else begin
               e = exp_q.pop_front();
               if (bus.out_data !== e) begin errors++; $display("FAIL b2b_data got %h want %h", bus.out_data, e); end
            end
         end
         if (acc2 == 0 && bus.in_ready) acc2 = c;
         @(posedge clk);
         if (acc2 == c) #1 bus.in_valid = 1'b0;
      end
      checks++; if (n_out != 2) begin errors++; $display("FAIL b2b_count got %0d want 2", n_out); end
      checks++; if (acc2 != 2) begin errors++; $display("FAIL b2b_second_accept got cycle %0d want 2", acc2); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_lost got %0d pending want 0", exp_q.size()); end
      exp_q.delete();
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b0;
   endtask

   task automatic test_reset_mid_mul;
      bit ok, seen; int lat; logic [15:0] e;
      drive_op(OP_MUL, 16'h1234, 16'h5678, ok);
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL midmul_reset got v=%b d=%h r=%b busy=%b want v=0 d=0000 r=1 busy=0",
                  bus.out_valid, bus.out_data, bus.in_ready, bus.busy);
      end
      rst = 1'b0;
      bus.out_ready = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         if (bus.out_valid) seen = 1'b1;
      end
      bus.out_ready = 1'b0;
      checks++; if (seen) begin errors++; $display("FAIL midmul_ghost got out_valid pulse want none"); end
      exp_q.push_back(16'h0002);
      drive_op(OP_ADD, 16'h0001, 16'h0001, ok);
      wait_valid(lat, ok);
      e = exp_q.pop_front();
      checks++; if (!ok || bus.out_data !== e) begin errors++; $display("FAIL midmul_after_add got %h want %h", bus.out_data, e); end
      consume();
   endtask

   task automatic test_random;
      localparam int N = 4000;
      int  n_got, n_bad, n_sent, cyc;
      bit  drv_fail;
      n_got = 0; n_bad = 0; n_sent = 0; drv_fail = 1'b0;
      exp_q.delete();
      fork
         begin
            logic [1:0] op; logic [15:0] a, b; bit ok;
            for (int i = 0; i < N && !drv_fail; i++) begin
               op = 2'($urandom);
               a  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
               b  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
               exp_q.push_back(ref_op(op, a, b));
               drive_op(op, a, b, ok);
               if (!ok) drv_fail = 1'b1;
               else n_sent++;
               repeat ($urandom_range(0, 1)) @(posedge clk);
            end
         end
         begin
            logic [15:0] e;
            cyc = 0;
            while (n_got < N && cyc < 80000 && !drv_fail) begin
               @(negedge clk);
               cyc++;
               bus.out_ready = ($urandom_range(0, 9) < 7);
               if (bus.out_valid && bus.out_ready) begin
                  n_got++;
                  if (exp_q.size() == 0) begin
                     n_bad++;
                     if (n_bad < 10) $display("FAIL rand_extra got %h want no output", bus.out_data);
                  end else begin
                     e = exp_q.pop_front();
                     if (bus.out_data !== e) begin
                        n_bad++;
                        if (n_bad < 10) $display("FAIL rand_data[%0d] got %h want %h", n_got, bus.out_data, e);
                     end
                  end
               end
            end
            @(posedge clk);
            #1 bus.out_ready = 1'b0;
         end
      join
      checks++; if (n_bad != 0) begin errors++; $display("FAIL rand_mismatches got %0d want 0", n_bad); end
      checks++; if (n_got != N || n_sent != N) begin errors++; $display("FAIL rand_count got %0d/%0d want %0d", n_got, n_sent, N); end
   endtask

   initial begin
      test_reset();
      test_add_hold();
      test_xor_sub();
      test_mul();
      test_back_to_back();
      test_reset_mid_mul();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
